seq_checker: RTL

//  Receive-side monitor for the 3-bit number-sequence generator. Samples

---
 rtl/seq_checker.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/seq_checker.sv
// Receive-side flywheel checker for the 3-bit number-sequence generator.
// Optional first-mismatch capture port set is enabled by defining SEQ_CHK_CAPTURE_EN.
module seq_checker #(
   parameter int DWELL    = 3,
   parameter int LOCK_CNT = 4,
   parameter int MISS_MAX = 2,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [2:0]       number,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt,
   output logic [2:0]       phase
`ifdef SEQ_CHK_CAPTURE_EN
   ,
   output logic [2:0]       cap_exp,
   output logic [2:0]       cap_got,
   output logic             cap_vld
`endif
);

   // Position only needs 3 bits for short dwells; longer dwells widen it and phase
   // then shows the low bits.
   localparam int POS_W = (DWELL + 3 < 8) ? 3 : 5;
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(DWELL + 3);
   localparam logic [3:0]       LOCK_C   = 4'(LOCK_CNT);
   localparam logic [3:0]       MISS_C   = 4'(MISS_MAX);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [3:0]         match_q, match_d;
   logic [3:0]         miss_q, miss_d;
   logic               locked_q, locked_d;
   logic               pulse_q, pulse_d;
   logic [ERR_W-1:0]   err_q, err_d, err_base;
   logic [POS_W-1:0]   nxt_pos;
   logic [2:0]         exp_nxt;
   logic               hit;
`ifdef SEQ_CHK_CAPTURE_EN
   logic [2:0]         cexp_q, cexp_d, cgot_q, cgot_d;
   logic               cvld_q, cvld_d, cvld_base;
`endif

   function automatic logic [2:0] exp_code(input logic [POS_W-1:0] p);
      logic [2:0] code;
      if (p == '0)
         code = 3'b000;
      else if (p == POS_W'(1))
         code = 3'b101;
      else if (p == POS_W'(2))
         code = 3'b001;
      else if (p == LAST_POS)
         code = 3'b110;
      else
         code = 3'b011;
      return code;
   endfunction

   assign nxt_pos = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
   assign exp_nxt = exp_code(nxt_pos);
   assign hit     = (number == exp_nxt);

   // Next-state logic; clr is folded into the error-count base first so that a
   // mismatch on the same edge lands on 1 rather than on the old count.
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      match_d  = match_q;
      miss_d   = miss_q;
      pulse_d  = 1'b0;
      err_base = clr ? '0 : err_q;
      err_d    = err_base;
`ifdef SEQ_CHK_CAPTURE_EN
      cvld_base = clr ? 1'b0 : cvld_q;
      cexp_d    = clr ? 3'b000 : cexp_q;
      cgot_d    = clr ? 3'b000 : cgot_q;
      cvld_d    = cvld_base;
`endif
      if (en) begin
         case (state_q)
            HUNT: begin
               pos_d = '0;
               if (number == 3'b000) begin
                  state_d = ACQ;
                  match_d = '0;
               end
            end
            ACQ: begin
               if (hit) begin
                  pos_d = nxt_pos;
                  if (match_q + 4'd1 == LOCK_C) begin
                     state_d = LOCKED;
                     match_d = '0;
                     miss_d  = '0;
                  end else begin
                     match_d = match_q + 4'd1;
                  end
               end else if (number == 3'b000) begin
                  pos_d   = '0;
                  match_d = '0;
               end else begin
                  state_d = HUNT;
                  pos_d   = '0;
                  match_d = '0;
               end
            end
            LOCKED: begin
               pos_d = nxt_pos;
               if (hit) begin
                  miss_d = '0;
               end else begin
                  pulse_d = 1'b1;
                  err_d   = (err_base == '1) ? err_base : err_base + ERR_W'(1);
`ifdef SEQ_CHK_CAPTURE_EN
                  if (!cvld_base) begin
                     cexp_d = exp_nxt;
                     cgot_d = number;
                     cvld_d = 1'b1;
                  end
`endif
                  if (miss_q + 4'd1 == MISS_C) begin
                     state_d = HUNT;
                     pos_d   = '0;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_q + 4'd1;
                  end
               end
            end
            default: begin
               state_d = HUNT;
               pos_d   = '0;
               match_d = '0;
               miss_d  = '0;
            end
         endcase
      end
      locked_d = (state_d == LOCKED);
   end

   // State register; reset takes priority over en and clr.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= HUNT;
         pos_q    <= '0;
         match_q  <= '0;
         miss_q   <= '0;
         locked_q <= 1'b0;
         pulse_q  <= 1'b0;
         err_q    <= '0;
`ifdef SEQ_CHK_CAPTURE_EN
         cexp_q   <= 3'b000;
         cgot_q   <= 3'b000;
         cvld_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         match_q  <= match_d;
         miss_q   <= miss_d;
         locked_q <= locked_d;
         pulse_q  <= pulse_d;
         err_q    <= err_d;
`ifdef SEQ_CHK_CAPTURE_EN
         cexp_q   <= cexp_d;
         cgot_q   <= cgot_d;
         cvld_q   <= cvld_d;
`endif
      end
   end

   assign locked    = locked_q;
   assign err_pulse = pulse_q;
   assign err_cnt   = err_q;
   assign phase     = pos_q[2:0];
`ifdef SEQ_CHK_CAPTURE_EN
   assign cap_exp   = cexp_q;
   assign cap_got   = cgot_q;
   assign cap_vld   = cvld_q;
`endif

endmodule
